// File: rtl/systolic_array.sv
// Weight-stationary NxN MAC array: activations move right, partial sums move down, weights stay put.
// Weights shift in row-wise on clk_w (held while scan_en=1); compute produces one registered result per column per clk.
module systolic_array #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          clk_w,
  input  logic                                          scan_en,
  input  logic [SYSTOLIC_SIZE-1:0]                      PE_disable,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]         weight_flat,
  input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]     activation_flat,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]    partial_sum_in_flat,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]    partial_sum_flat
);
  localparam int N  = SYSTOLIC_SIZE;
  localparam int WW = WEIGHT_WIDTH;
  localparam int AW = ACTIVATION_WIDTH;
  localparam int PW = PARTIAL_SUM_WIDTH;

  logic [WW-1:0] w          [N][N];
  logic [AW-1:0] a          [N][N];
  logic [PW-1:0] p          [N][N];
  logic [AW-1:0] act_here   [N][N];
  logic [PW-1:0] psum_above [N][N];
  logic [PW-1:0] prod       [N][N];

  // Weight shift chain; each row enters at column 0, so columns are presented last-first.
  always_ff @(posedge clk_w) begin
    for (int r = 0; r < N; r++) begin
      if (!rst_n) begin
        for (int c = 0; c < N; c++) w[r][c] <= '0;
      end else if (!scan_en) begin
        w[r][0] <= weight_flat[r*WW +: WW];
        for (int c = 1; c < N; c++) w[r][c] <= w[r][c-1];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      act_here[r][0] = activation_flat[r*AW +: AW];
      for (int c = 1; c < N; c++) act_here[r][c] = a[r][c-1];
    end
    for (int c = 0; c < N; c++) begin
      psum_above[0][c] = partial_sum_in_flat[c*PW +: PW];
      for (int r = 1; r < N; r++) psum_above[r][c] = p[r-1][c];
    end
    // Products are taken modulo 2^PW; the wrapping sum makes that equivalent to full-width.
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        prod[r][c] = PE_disable[r] ? '0 : PW'(act_here[r][c]) * PW'(w[r][c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!rst_n) begin
          a[r][c] <= '0;
          p[r][c] <= '0;
        end else begin
          a[r][c] <= act_here[r][c];
          p[r][c] <= psum_above[r][c] + prod[r][c];
        end
      end
    end
  end

  always_comb begin
    partial_sum_flat = '0;
    for (int c = 0; c < N; c++) partial_sum_flat[c*PW +: PW] = p[N-1][c];
  end

endmodule

// File: tb/tb_systolic_array.sv
// Randomized scoreboard bench for systolic_array: expected column sums from matrix arithmetic.
// Latency: results compared at the cycle due per the row/column skew of the specification.
// Backpressure: none; stimulus is driven every cycle, a monitor compares each due result.
module tb_systolic_array;
    localparam int N    = 8;
    localparam int WW   = 8;
    localparam int AW   = 8;
    localparam int PW   = 19;
    localparam int MAXM = 16;
    localparam longint MASK = (longint'(1) << PW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clk_w = 1'b0;
    logic              scan_en = 1'b0;
    logic [N-1:0]      pe_dis = '0;
    logic [N*WW-1:0]   weight_flat = '0;
    logic [N*AW-1:0]   activation_flat = '0;
    logic [N*PW-1:0]   partial_sum_in_flat = '0;
    logic [N*PW-1:0]   partial_sum_flat;

    systolic_array #(
        .SYSTOLIC_SIZE(N), .WEIGHT_WIDTH(WW), .ACTIVATION_WIDTH(AW), .PARTIAL_SUM_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_w(clk_w), .scan_en(scan_en),
        .PE_disable(pe_dis), .weight_flat(weight_flat), .activation_flat(activation_flat),
        .partial_sum_in_flat(partial_sum_in_flat), .partial_sum_flat(partial_sum_flat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; int col; longint val; } exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    longint wm    [N][N];
    int     wl    [N][N];
    int     act_b [N][MAXM];
    longint ps_b  [MAXM][N];

    logic [PW-1:0] mon_got;

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                mon_got = partial_sum_flat[sb[i].col*PW +: PW];
                n_checks++;
                if (mon_got === PW'(sb[i].val)) n_pass++;
                else $display("FAIL psum col%0d cycle%0d: got %0d expected %0d",
                              sb[i].col, cyc, mon_got, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic push_exp(input int due, input int col, input longint val);
        exp_t e;
        e.due = due; e.col = col; e.val = val;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        activation_flat     = '0;
        partial_sum_in_flat = '0;
        weight_flat         = '0;
    endtask

    task automatic load_weights(input bit frozen);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            for (int r = 0; r < N; r++) weight_flat[r*WW +: WW] = WW'(wl[r][N-1-k]);
            #1 clk_w = 1'b1;
            #2 clk_w = 1'b0;
        end
        if (!frozen)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) wm[r][c] = longint'(wl[r][c]);
    endtask

    task automatic run_batch(input int m_cnt, input logic [N-1:0] dis);
        int t0;
        longint s;
        @(negedge clk);
        pe_dis = dis;
        t0 = cyc;
        for (int m = 0; m < m_cnt; m++) begin
            for (int c = 0; c < N; c++) begin
                s = ps_b[m][c];
                for (int r = 0; r < N; r++)
                    if (!dis[r]) s += longint'(act_b[r][m]) * wm[r][c];
                push_exp(t0 + m + N + c, c, s & MASK);
            end
        end
        for (int t = 0; t < m_cnt + 2*N; t++) begin
            if (t > 0) @(negedge clk);
            for (int r = 0; r < N; r++) begin
                activation_flat[r*AW +: AW] = '0;
                if (t - r >= 0 && t - r < m_cnt) activation_flat[r*AW +: AW] = AW'(act_b[r][t-r]);
            end
            for (int c = 0; c < N; c++) begin
                partial_sum_in_flat[c*PW +: PW] = '0;
                if (t - c >= 0 && t - c < m_cnt) partial_sum_in_flat[c*PW +: PW] = PW'(ps_b[t-c][c]);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic fill_batch(input int act_mode, input int act_val, input int ps_mode);
        for (int m = 0; m < MAXM; m++) begin
            for (int k = 0; k < N; k++) begin
                case (act_mode)
                    0:       act_b[k][m] = act_val;
                    1:       act_b[k][m] = k*8 + m + 1;
                    default: act_b[k][m] = int'($urandom_range(0, 255));
                endcase
                case (ps_mode)
                    0:       ps_b[m][k] = 0;
                    1:       ps_b[m][k] = longint'(k + 100);
                    default: ps_b[m][k] = longint'($urandom_range(0, (1 << PW) - 1));
                endcase
            end
        end
    endtask

    task automatic set_wl(input int mode, input int val);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                case (mode)
                    0:       wl[r][c] = val;
                    1:       wl[r][c] = (r == c) ? 1 : 0;
                    default: wl[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    initial begin
        int t0;
        @(negedge clk);
        rst_n = 1'b0;
        weight_flat = {$urandom, $urandom};
        #1 clk_w = 1'b1;
        #1 clk_w = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) wm[r][c] = 0;
        t0 = cyc;
        for (int c = 0; c < N; c++) push_exp(t0 + 2, c, 0);
        repeat (2) begin
            activation_flat     = {$urandom, $urandom};
            partial_sum_in_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
            pe_dis              = N'($urandom);
            @(negedge clk);
        end
        n_checks++;
        if (partial_sum_flat === '0) n_pass++;
        else $display("FAIL reset: partial_sum_flat=%h expected 0", partial_sum_flat);
        rst_n = 1'b1;
        pe_dis = '0;
        idle_inputs();

        fill_batch(2, 0, 2);
        run_batch(4, '0);

        set_wl(1, 0); load_weights(1'b0);
        fill_batch(1, 0, 0);
        run_batch(8, '0);

        set_wl(0, 255); load_weights(1'b0);
        fill_batch(0, 255, 0);
        run_batch(4, '0);
        run_batch(4, 8'b0000_0001);

        set_wl(0, 0); load_weights(1'b0);
        fill_batch(2, 0, 1);
        run_batch(4, '0);
        n_checks++;
        if (partial_sum_flat === '0) n_pass++;
        else $display("FAIL idle after psum chaining: partial_sum_flat=%h expected 0", partial_sum_flat);

        set_wl(0, 1); load_weights(1'b0);
        scan_en = 1'b1;
        set_wl(0, 2); load_weights(1'b1);
        scan_en = 1'b0;
        fill_batch(0, 1, 0);
        run_batch(3, '0);
        load_weights(1'b0);
        run_batch(3, '0);

        set_wl(2, 0); load_weights(1'b0);
        fill_batch(0, 0, 0);
        run_batch(2, '0);
        n_checks++;
        if (partial_sum_flat === '0) n_pass++;
        else $display("FAIL zero inputs: partial_sum_flat=%h expected 0", partial_sum_flat);

        for (int it = 0; it < 4; it++) begin
            set_wl(2, 0); load_weights(1'b0);
            fill_batch(2, 0, 2);
            run_batch(int'($urandom_range(1, 12)), N'($urandom));
        end

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard: %0d results never compared", sb.size());
        while (sb.size() > 0) begin
            $display("FAIL timeout col%0d: result due at cycle %0d never compared, expected %0d",
                     sb[0].col, sb[0].due, sb[0].val);
            void'(sb.pop_front());
        end

        if (n_pass == n_checks) $display("PASS");
        else $display("FAIL");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
